// File: rtl/mill_modif_frame_rx_if.sv
// Byte-stream bus between the modified Miller decoder, the frame deserializer and its consumer.
// The slave modport is the deserializer; the master modport drives decoder bits and consumer ready.
interface mill_modif_frame_rx_if;
    logic       in_bit;
    logic       in_bit_stb;
    logic       in_sof;
    logic       in_eof;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_perr;
    logic       out_valid;
    logic       out_frame_done;
    logic       out_frame_err;
    logic       out_short;
    logic [5:0] out_byte_cnt;
    logic       out_overflow;
    logic       out_crc_ok;

    modport master (
        output in_bit, in_bit_stb, in_sof, in_eof, in_ready,
        input  out_byte, out_perr, out_valid, out_frame_done, out_frame_err,
               out_short, out_byte_cnt, out_overflow, out_crc_ok
    );

    modport slave (
        input  in_bit, in_bit_stb, in_sof, in_eof, in_ready,
        output out_byte, out_perr, out_valid, out_frame_done, out_frame_err,
               out_short, out_byte_cnt, out_overflow, out_crc_ok
    );
endinterface

// File: rtl/mill_modif_frame_rx.sv
// ISO 14443-A PCD->PICC frame deserializer: LSB-first bytes, odd parity, short frames, output FIFO.
// Optional CRC_A residue check is compiled in when MILL_CRC_CHECK_EN is defined.
module mill_modif_frame_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  in_PoR,
    mill_modif_frame_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [5:0] byte_cnt_reg, byte_cnt_next;
    logic       frame_done_reg, frame_done_next;
    logic       frame_err_reg, frame_err_next;
    logic       short_reg, short_next;
    logic       overflow_reg, overflow_next;

    logic          push, pop, fifo_full, push_ok;
    logic [8:0]    push_data;
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;

`ifdef MILL_CRC_CHECK_EN
    logic [15:0] crc_reg, crc_next;
    logic        crc_ok_reg, crc_ok_next;

    // Reflected CRC_A (poly 0x8408), one byte LSB first.
    function automatic logic [15:0] crc_a_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
            else                c = c >> 1;
        end
        return c;
    endfunction
`endif

    assign pop       = (count_reg != '0) && bus.in_ready;
    assign fifo_full = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign push_ok   = push && (!fifo_full || pop);

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        frame_done_next = 1'b0;
        frame_err_next  = frame_err_reg;
        short_next      = short_reg;
        overflow_next   = overflow_reg;
        push            = 1'b0;
        push_data       = '0;
`ifdef MILL_CRC_CHECK_EN
        crc_next        = crc_reg;
        crc_ok_next     = crc_ok_reg;
`endif
        if (bus.in_sof) begin
            // A start of frame restarts from any state; FIFO contents survive.
            state_next     = DATA;
            shift_next     = '0;
            bit_cnt_next   = '0;
            byte_cnt_next  = '0;
            frame_err_next = 1'b0;
            short_next     = 1'b0;
            overflow_next  = 1'b0;
`ifdef MILL_CRC_CHECK_EN
            crc_next       = 16'h6363;
            crc_ok_next    = 1'b0;
`endif
        end else begin
            case (state_reg)
                DATA: if (bus.in_bit_stb) begin
                    shift_next   = {bus.in_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_next == 4'd8) state_next = PARITY;
                end
                PARITY: if (bus.in_bit_stb) begin
                    push         = 1'b1;
                    push_data    = {(bus.in_bit != ~^shift_reg), shift_reg};
                    bit_cnt_next = '0;
                    state_next   = DATA;
                    if (byte_cnt_reg != 6'd63) byte_cnt_next = byte_cnt_reg + 6'd1;
`ifdef MILL_CRC_CHECK_EN
                    crc_next     = crc_a_byte(crc_reg, shift_reg);
`endif
                end
                DONE: begin
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end
                default: ;
            endcase

            // End of frame is judged against counters already updated by a same-cycle bit.
            if (bus.in_eof && (state_reg == DATA || state_reg == PARITY)) begin
                state_next = DONE;
                if (bit_cnt_next == 4'd7 && byte_cnt_next == 6'd0) begin
                    push          = 1'b1;
                    push_data     = {2'b00, shift_next[7:1]};
                    short_next    = 1'b1;
                    byte_cnt_next = 6'd1;
                end else if (bit_cnt_next != 4'd0) begin
                    frame_err_next = 1'b1;
                end
`ifdef MILL_CRC_CHECK_EN
                crc_ok_next = (crc_next == 16'h0000) && (byte_cnt_next >= 6'd3) && !short_next;
`endif
            end
        end
        if (push && !push_ok) overflow_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (in_PoR) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            byte_cnt_reg   <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            short_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
`ifdef MILL_CRC_CHECK_EN
            crc_reg        <= 16'h6363;
            crc_ok_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
            short_reg      <= short_next;
            overflow_reg   <= overflow_next;
`ifdef MILL_CRC_CHECK_EN
            crc_reg        <= crc_next;
            crc_ok_reg     <= crc_ok_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (in_PoR) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Head is forced to zero when empty so uninitialised storage never shows.
    assign bus.out_valid      = (count_reg != '0);
    assign bus.out_byte       = bus.out_valid ? fifo_mem[rd_ptr_reg][7:0] : 8'h00;
    assign bus.out_perr       = bus.out_valid ? fifo_mem[rd_ptr_reg][8]   : 1'b0;
    assign bus.out_frame_done = frame_done_reg;
    assign bus.out_frame_err  = frame_err_reg;
    assign bus.out_short      = short_reg;
    assign bus.out_byte_cnt   = byte_cnt_reg;
    assign bus.out_overflow   = overflow_reg;
`ifdef MILL_CRC_CHECK_EN
    assign bus.out_crc_ok     = crc_ok_reg;
`else
    assign bus.out_crc_ok     = 1'b0;
`endif
endmodule

// File: tb/tb_mill_modif_frame_rx.sv
// Scoreboard bench for mill_modif_frame_rx: expected bytes and frame status are queued by the
// stimulus and checked by independent monitors when the DUT presents them.
module tb_mill_modif_frame_rx;
    logic clk = 1'b0;
    logic in_PoR;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [8:0] exp_bytes [$];   // {perr, byte}
    logic [8:0] exp_status [$];  // {err, short, byte_cnt[5:0], crc_ok}
    int         exp_eof_cyc [$];

`ifdef MILL_CRC_CHECK_EN
    localparam logic HLTA_CRC_OK = 1'b1;
`else
    localparam logic HLTA_CRC_OK = 1'b0;
`endif

    mill_modif_frame_rx_if bus ();

    mill_modif_frame_rx #(.FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .in_PoR (in_PoR),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Byte monitor: every accepted output byte must match the queue head.
    always @(negedge clk) begin
        if (!in_PoR && bus.out_valid && bus.in_ready) begin
            if (exp_bytes.size() == 0) begin
                check("unexpected_byte", {23'd0, bus.out_perr, bus.out_byte}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_bytes.pop_front();
                check("byte", {23'd0, bus.out_perr, bus.out_byte}, {23'd0, e});
            end
        end
    end

    // Frame status monitor, including eof-to-done latency.
    always @(negedge clk) begin
        if (!in_PoR && bus.out_frame_done) begin
            if (exp_status.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] s;
                int         ec;
                s  = exp_status.pop_front();
                ec = exp_eof_cyc.pop_front();
                check("frame_status", {23'd0, bus.out_frame_err, bus.out_short, bus.out_byte_cnt,
                      bus.out_crc_ok}, {23'd0, s});
                check("done_latency", cyc - ec, 32'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in_bit = b;
        bus.in_bit_stb = 1'b1;
        tick();
        bus.in_bit_stb = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par, input logic exp_perr,
                             input logic expect_out);
        if (expect_out) exp_bytes.push_back({exp_perr, b});
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
    endtask

    task automatic sof();
        bus.in_sof = 1'b1;
        tick();
        bus.in_sof = 1'b0;
        tick();
    endtask

    task automatic eof(input logic err, input logic shrt, input logic [5:0] cnt, input logic crc);
        exp_status.push_back({err, shrt, cnt, crc});
        exp_eof_cyc.push_back(cyc);
        bus.in_eof = 1'b1;
        tick();
        bus.in_eof = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    bus.out_valid, 0);
        check({tag, "_byte"},     bus.out_byte, 0);
        check({tag, "_status"},   {bus.out_frame_done, bus.out_frame_err, bus.out_short,
                                   bus.out_overflow, bus.out_crc_ok}, 0);
        check({tag, "_byte_cnt"}, bus.out_byte_cnt, 0);
    endtask

    task automatic reqa();
        logic [6:0] bits;
        bits = 7'b0100110;  // 0x26, sent LSB first: 0,1,1,0,0,1,0
        sof();
        exp_bytes.push_back(9'h026);
        for (int i = 0; i < 7; i++) send_bit(bits[i]);
        eof(1'b0, 1'b1, 6'd1, 1'b0);
    endtask

    initial begin
        in_PoR = 1'b1;
        bus.in_bit = 1'b0; bus.in_bit_stb = 1'b0; bus.in_sof = 1'b0;
        bus.in_eof = 1'b0; bus.in_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        in_PoR = 1'b0;
        tick();

        // REQA short frame
        reqa();

        // HLTA with valid CRC_A
        sof();
        send_byte(8'h50, 1'b1, 1'b0, 1'b1);
        send_byte(8'h00, 1'b1, 1'b0, 1'b1);
        send_byte(8'h57, 1'b0, 1'b0, 1'b1);
        send_byte(8'hCD, 1'b0, 1'b0, 1'b1);
        eof(1'b0, 1'b0, 6'd4, HLTA_CRC_OK);

        // Parity error: 0xA5 needs parity 1, send 0
        sof();
        send_byte(8'hA5, 1'b0, 1'b1, 1'b1);
        eof(1'b0, 1'b0, 6'd1, 1'b0);

        // Overflow: 6 bytes into a 4-deep FIFO with the consumer stalled
        bus.in_ready = 1'b0;
        sof();
        send_byte(8'h01, 1'b0, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 1'b0, 1'b1);
        send_byte(8'h03, 1'b1, 1'b0, 1'b1);
        send_byte(8'h04, 1'b0, 1'b0, 1'b1);
        send_byte(8'h05, 1'b1, 1'b0, 1'b0);
        send_byte(8'h06, 1'b1, 1'b0, 1'b0);
        check("ovf_set", bus.out_overflow, 1);
        check("ovf_head_held", {bus.out_valid, bus.out_byte}, 9'h101);
        eof(1'b0, 1'b0, 6'd6, 1'b0);
        check("ovf_sticky_after_eof", bus.out_overflow, 1);
        bus.in_ready = 1'b1;
        repeat (6) tick();
        check("ovf_drained_valid", bus.out_valid, 0);
        bus.in_sof = 1'b1;
        tick();
        bus.in_sof = 1'b0;
        check("ovf_cleared_by_sof", bus.out_overflow, 0);
        check("byte_cnt_cleared_by_sof", bus.out_byte_cnt, 0);

        // Framing error: one byte then 3 bits
        sof();
        send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        eof(1'b1, 1'b0, 6'd1, 1'b0);

        // Reset mid-frame after two buffered bytes, then REQA again
        bus.in_ready = 1'b0;
        sof();
        send_byte(8'h93, 1'b1, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0, 1'b0);
        check("pre_reset_valid", bus.out_valid, 1);
        in_PoR = 1'b1;
        tick();
        in_PoR = 1'b0;
        check_all_zero("midreset");
        bus.in_ready = 1'b1;
        tick();
        reqa();

        repeat (10) tick();
        check("bytes_left", exp_bytes.size(), 0);
        check("frames_left", exp_status.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
